// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the branch predictor update controller
//
// Holds the default table index width, the derived table size, the update
// record carried through the update FIFO, and the controller FSM encoding.

package bpu_pkg;

    localparam int BPU_INDEX_W = 8;
    localparam int TABLE_SIZE  = 2 ** BPU_INDEX_W;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bpu_update_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_upd_state_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// rtl/bpu_upd_fifo.sv - two-write/one-read FIFO of resolved-branch updates
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard all contents (pointers and count to zero)
//   wr_en0/wr_data0       first write, lands at the write pointer
//   wr_en1/wr_data1       second write, lands behind the first (or at the
//                         write pointer when it is the only write)
//   rd_en                 pop the head (caller guarantees non-empty)
//   rd_data               current head entry
//   count                 occupancy, log2(DEPTH)+1 bits
//   full2                 fewer than two free entries
//   empty                 no entries

module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en0,
    input  bpu_update_t                wr_data0,
    input  logic                       wr_en1,
    input  bpu_update_t                wr_data1,
    input  logic                       rd_en,
    output bpu_update_t                rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full2,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bpu_update_t        mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         n_wr;
    bpu_update_t        first_data;

    assign n_wr       = {1'b0, wr_en0} + {1'b0, wr_en1};
    // Slot order is preserved: a lone slot1 write takes the first position.
    assign first_data = wr_en0 ? wr_data0 : wr_data1;

    always_ff @(posedge clk) begin
        if (wr_en0 || wr_en1) begin
            mem[wptr] <= first_data;
        end
        if (wr_en0 && wr_en1) begin
            mem[wptr + PTR_W'(1)] <= wr_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + PTR_W'(n_wr);
            rptr <= rptr + PTR_W'(rd_en);
            cnt  <= cnt + CNT_W'(n_wr) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rptr];
    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full2   = (cnt > CNT_W'(DEPTH - 2));

endmodule

// File: rtl/bpu_update_ctrl.sv
// rtl/bpu_update_ctrl.sv - sequences update and clear writes into the branch predictor tables
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   upd_valid/upd_pc/upd_taken two resolved-branch slots per cycle, slot 0 older
//   upd_ready                  both slots may be accepted this cycle
//   clear_req                  one-cycle request for a full table clear
//   update_en/pc_dispatch/taken_actual   single predictor update port
//   init_en/init_index/init_busy         table clear sweep
//   perf_upd_cnt/perf_taken_cnt/perf_stall_cnt  performance counters
//
// Build option: BPU_UPD_PERF_EN builds the performance counters; without it
// the perf ports are tied to zero.

module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int INDEX_W = BPU_INDEX_W
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          upd_valid,
    input  logic [1:0][31:0]    upd_pc,
    input  logic [1:0]          upd_taken,
    output logic                upd_ready,
    input  logic                clear_req,
    output logic                update_en,
    output logic [31:0]         pc_dispatch,
    output logic                taken_actual,
    output logic                init_en,
    output logic [INDEX_W-1:0]  init_index,
    output logic                init_busy,
    output logic [31:0]         perf_upd_cnt,
    output logic [31:0]         perf_taken_cnt,
    output logic [31:0]         perf_stall_cnt
);

    localparam int                 CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [INDEX_W-1:0] INDEX_LAST = '1;

    bpu_upd_state_t     state;
    bpu_update_t        slot0;
    bpu_update_t        slot1;
    bpu_update_t        head;
    logic               fifo_full2;
    logic               fifo_empty;
    // Occupancy is kept on the FIFO interface for debug visibility only.
    logic [CNT_W-1:0]   fifo_count_unused;
    logic               pop;

    assign slot0 = '{pc: upd_pc[0], taken: upd_taken[0]};
    assign slot1 = '{pc: upd_pc[1], taken: upd_taken[1]};

    // Ready is only offered when a full pair fits, so upstream never has to
    // split a pair across cycles.
    assign upd_ready = (state == RUN) && !fifo_full2 && !clear_req;
    assign pop       = (state == RUN) && !fifo_empty && !clear_req;

    bpu_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear_req),
        .wr_en0   (upd_ready && upd_valid[0]),
        .wr_data0 (slot0),
        .wr_en1   (upd_ready && upd_valid[1]),
        .wr_data1 (slot1),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (fifo_count_unused),
        .full2    (fifo_full2),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            init_en      <= 1'b0;
            init_index   <= '0;
            init_busy    <= 1'b1;
            update_en    <= 1'b0;
            pc_dispatch  <= '0;
            taken_actual <= 1'b0;
        end else if (clear_req) begin
            // Sweep starts on this edge, from RUN or restarting mid-INIT.
            state      <= INIT;
            init_en    <= 1'b1;
            init_index <= '0;
            init_busy  <= 1'b1;
            update_en  <= 1'b0;
        end else if (state == INIT) begin
            update_en <= 1'b0;
            if (!init_en) begin
                // First edge out of reset: begin writing index 0.
                init_en    <= 1'b1;
                init_index <= '0;
            end else if (init_index == INDEX_LAST) begin
                init_en    <= 1'b0;
                init_index <= '0;
                init_busy  <= 1'b0;
                state      <= RUN;
            end else begin
                init_index <= init_index + INDEX_W'(1);
            end
        end else begin
            update_en <= pop;
            if (pop) begin
                pc_dispatch  <= head.pc;
                taken_actual <= head.taken;
            end
        end
    end

`ifdef BPU_UPD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_upd_cnt   <= '0;
            perf_taken_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (update_en) begin
                perf_upd_cnt <= perf_upd_cnt + 32'd1;
            end
            if (update_en && taken_actual) begin
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
            end
            if ((|upd_valid) && !upd_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_upd_cnt   = '0;
    assign perf_taken_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/bpu_update_ctrl.md
Name: bpu_update_ctrl

Overview:
Sequences all writes into the two-way branch predictor's history/pattern tables.
- Accepts up to two resolved-branch updates per cycle from the backend, buffers them, and issues exactly one update per cycle on the predictor's single update port.
- Runs a table-clear sweep after reset or on request. The predictor tables never need a bulk reset; they are cleared one index per cycle.

Parameters:
DEPTH, 8, update FIFO entries; power of two, >= 4
INDEX_W, 8, predictor table index width (table size 2^INDEX_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
upd_valid  in  2  per-slot resolved-branch valid; slot 0 is older
upd_pc  in  2x32  per-slot branch PC
upd_taken  in  2  per-slot actual direction
upd_ready  out  1  both slots may be accepted this cycle
clear_req  in  1  one-cycle pulse requesting a full table clear
update_en  out  1  predictor update strobe
pc_dispatch  out  32  PC for the update
taken_actual  out  1  direction for the update
init_en  out  1  clear-write strobe for the predictor tables
init_index  out  INDEX_W  table index being cleared
init_busy  out  1  clear sweep in progress

Behaviour:
- Single clock domain; clock port is clk, reset port is rst. Reset is synchronous and active-high.
- Reset values: update_en=0, pc_dispatch=0, taken_actual=0, init_en=0, init_index=0, init_busy=1, FIFO empty.
- FSM states: INIT, RUN.
  - rst -> INIT.
  - INIT: init_en=1 and init_index increments 0 .. 2^INDEX_W-1, one index per cycle.
  - After index 2^INDEX_W-1 is written, the next state is RUN and init_busy=0.
  - An INIT sweep therefore lasts exactly 2^INDEX_W cycles.
- RUN + clear_req: FIFO contents are discarded, update_en deasserts on the next edge, and the FSM returns to INIT with init_index=0.
- clear_req during INIT restarts the sweep from index 0.
- upd_ready = (state==RUN) && (free entries >= 2) && !clear_req. It is combinational from registered state plus clear_req.
- Enqueue happens on a clock edge where upd_ready=1.
  - Valid slots are written in slot order: slot0, then slot1.
  - If only slot1 is valid, it takes one entry.
  - If upd_ready=0, the upstream holds its inputs; nothing is enqueued.
- Occupancy counter is log2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.
- Dequeue: in RUN with the FIFO non-empty, the head is popped each edge into registered outputs, giving update_en=1, pc_dispatch=pc, taken_actual=taken. Otherwise update_en=0.
- Latency: a pair accepted at edge E appears as follows.
  - Slot0 is on the outputs during the cycle after edge E+1.
  - Slot1 is on the outputs during the cycle after edge E+2.
  - There is no bypass path.
- Simultaneous enqueue and dequeue in the same edge is allowed. Occupancy changes by +writes-1.
- FIFO full: upd_ready=0. No overwrite and no drop.
- No update is ever issued during INIT. update_en and init_en are never high together.
- Reset mid-operation: all queued updates are lost and a fresh INIT begins.

Optional Feature:
Macro BPU_UPD_PERF_EN.
- Defined: adds 32-bit outputs, all reset to 0 and wrapping modulo 2^32.
  - perf_upd_cnt: +1 per update_en cycle.
  - perf_taken_cnt: +1 per update_en cycle with taken_actual=1.
  - perf_stall_cnt: +1 per cycle with |upd_valid && !upd_ready.
- Not defined: the same ports exist and are tied to 0, and no counter logic is built.

Decomposition:
- Package bpu_pkg holds:
  - INDEX_W default
  - TABLE_SIZE = 2^INDEX_W
  - typedef bpu_update_t {logic [31:0] pc; logic taken;}
  - FSM enum bpu_upd_state_t {INIT, RUN}
- One sub-module, bpu_upd_fifo: a two-write/one-read FIFO of bpu_update_t with count, full2 (free<2) and empty outputs, plus a flush input.
- The FSM and output registers stay in bpu_update_ctrl.

Test Plan:
1. Release rst -> init_en=1 for exactly 256 cycles with init_index 0..255, then init_busy=0 and upd_ready=1. update_en stays 0 throughout.
2. RUN, apply {valid=2'b11, pc0=0x1C000100/taken=1, pc1=0x1C000204/taken=0} for one edge -> update_en high for 2 consecutive cycles. Outputs are (0x1C000100,1), then (0x1C000204,0), starting the cycle after edge E+1.
3. RUN, drive valid=2'b11 every cycle with no gaps -> the FIFO fills and upd_ready drops to 0. No entry is lost, update_en stays 1 every cycle, and the output PC order matches the input order.
4. valid=2'b10 only, pc1=0x1C000300 -> exactly one update is issued with pc_dispatch=0x1C000300.
5. Queue 5 entries, then pulse clear_req -> the next edge has update_en=0 and a 256-cycle INIT. Afterwards the FIFO is empty and none of the 5 entries is ever issued.
6. Assert rst mid-INIT at index 100 -> the sweep restarts at index 0. With BPU_UPD_PERF_EN, step 3 with one forced stall cycle gives perf_stall_cnt=1 and perf_upd_cnt = number of issued updates.
